mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
Parametrised up/down modulo-N counter. Generalises the fixed 4-bit binary up counter to any width, a runtime modulus, a selectable direction and wrap/saturate/one-shot modes. Adds synchronous load and clear, plus terminal-count outputs for cascading. It is the building block for the 1-to-10M clock divider chain: one stage per decade, each stage's tc driving the next stage's en.

Parameters:
WIDTH, 4, counter width in bits (legal range 1..32)
RST_VAL, 0, value loaded into count on asynchronous reset (must be < 2^WIDTH)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; counts one step per clk edge when high
clr  input  1  synchronous clear to 0; overrides load and en
load  input  1  synchronous load of load_val; overrides en
load_val  input  WIDTH  value taken when load=1
up  input  1  direction: 1 = increment, 0 = decrement
max_val  input  WIDTH  terminal value; the sequence is 0..max_val (modulus max_val+1)
mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap (reserved)
count  output  WIDTH  current count (registered)
tc  output  1  combinational terminal count, for cascading
wrap  output  1  registered one-cycle pulse after a wrap
done  output  1  registered one-shot completion flag

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): count=RST_VAL, wrap=0, done=0. tc follows its equation.
- Per-edge priority: clr > load > (en & ~done) > hold.
- clr: count<=0, done<=0, wrap<=0.
- load: count<=load_val, done<=0, wrap<=0. Any load_val is accepted, including values > max_val.
- Terminal condition term:
  - up=1: count >= max_val.
  - up=0: count == 0.
- tc = en & term & ~done & ~clr & ~load. Purely combinational, with no register delay, so a cascaded stage steps on the same edge.
- Counting (en=1, done=0, no clr/load) when term=0: count <= count+1 (up) or count-1 (down), modulo 2^WIDTH; wrap<=0.
- Counting when term=1, by mode:
  - Wrap (00/11): up -> count<=0; down -> count<=max_val; wrap<=1 for exactly one cycle.
  - Saturate (01): count holds; wrap<=0; tc stays high every enabled cycle.
  - One-shot (10): count holds; done<=1; wrap<=0. done stays high until clr or load. While done=1, en is ignored and tc=0.
- Out-of-range count (count > max_val):
  - up: treated as terminal; wraps to 0 / saturates / completes per mode.
  - down: decrements normally toward 0.
- max_val=0:
  - count stays 0.
  - Wrap mode: tc=1 and wrap pulses on every enabled cycle, giving divide-by-1.
- max_val, up and mode may change on any cycle; they take effect on the next edge with no pipeline.
- en=0 (no clr/load): all registers hold; wrap<=0.
- Reset mid-count overrides everything immediately, including a pending wrap or done.
- Latency:
  - count updates 1 edge after the enabling condition.
  - wrap asserts on the edge the wrap happens and deasserts on the next edge.

Test Plan:
- Reset/idle: WIDTH=4, RST_VAL=3; assert rst_n=0 mid-cycle -> count=3, wrap=0, done=0 with no clk edge; release with en=0 -> count holds at 3.
- Decade wrap up: max_val=9, mode=00, up=1, en=1 from 0 for 12 edges -> count 1..9,0,1,2; tc=1 only while count=9; wrap=1 for the single cycle count=0 after 9.
- Down wrap and out-of-range: max_val=5, up=0, load_val=1 then count -> 1,0,5,4; wrap pulses once. Then load 12 with up=1 -> next edge count=0 and wrap=1.
- Saturate and one-shot: max_val=7, mode=01, up=1 -> count stops at 7 and tc stays 1. Repeat with mode=10 -> count stops at 7, done=1, tc=0, en ignored; clr -> count=0, done=0.
- Priority: drive clr=1, load=1 (load_val=6) and en=1 on the same edge -> count=0; then load=1, en=1 -> count=6, no increment.
- Cascade: two instances, WIDTH=4, max_val=9; stage1.en=stage0.tc; run 100 edges -> {stage1,stage0} = 00 again, stage1 wrap pulses once at edge 100.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Up/down modulo-N counter with wrap, saturate and one-shot modes.
// tc is combinational so a chain of stages advances on the same edge.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [WIDTH-1:0] max_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_WRAP_R  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             term;
    logic             step;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Counting up, anything at or beyond max_val is terminal.
    assign term = up ? (count_q >= max_val) : (count_q == '0);
    assign step = en & ~done_q & ~clr & ~load;
    assign tc   = step & term;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (clr) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (step) begin
            if (!term) begin
                count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else begin
                unique case (mode_s)
                    MODE_SAT: begin
                        count_d = count_q;
                    end
                    MODE_ONESHOT: begin
                        done_d = 1'b1;
                    end
                    MODE_WRAP, MODE_WRAP_R: begin
                        count_d = up ? '0 : max_val;
                        wrap_d  = 1'b1;
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_CNT;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomised and directed bench for mod_n_updown_counter,
// plus a two-stage decade cascade.
module tb_mod_n_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en, clr, load, up;
    logic [3:0] load_val, max_val;
    logic [1:0] mode;
    logic [3:0] count;
    logic       tc, wrap, done;

    logic       cen, cclr;
    logic [3:0] c0cnt, c1cnt;
    logic       tc0, tc1, w0, w1, d0, d1;

    int n_tests = 0;
    int n_fail  = 0;
    int mc, mw, md;

    mod_n_updown_counter #(.WIDTH(4), .RST_VAL(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up(up), .max_val(max_val), .mode(mode),
        .count(count), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_n_updown_counter #(.WIDTH(4), .RST_VAL(0)) c0 (
        .clk(clk), .rst_n(rst_n), .en(cen), .clr(cclr), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .max_val(4'd9), .mode(2'b00),
        .count(c0cnt), .tc(tc0), .wrap(w0), .done(d0)
    );

    mod_n_updown_counter #(.WIDTH(4), .RST_VAL(0)) c1 (
        .clk(clk), .rst_n(rst_n), .en(tc0), .clr(cclr), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .max_val(4'd9), .mode(2'b00),
        .count(c1cnt), .tc(tc1), .wrap(w1), .done(d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_term();
        if (up) return mc >= int'(max_val);
        return mc == 0;
    endfunction

    function automatic bit model_tc();
        return en && !md && !clr && !load && model_term();
    endfunction

    task automatic model_edge();
        bit t;
        t  = model_term();
        mw = 0;
        if (clr) begin
            mc = 0;
            md = 0;
        end else if (load) begin
            mc = int'(load_val);
            md = 0;
        end else if (en && md == 0) begin
            if (!t) mc = up ? mc + 1 : mc - 1;
            else if (mode == 2'b01) mc = mc;
            else if (mode == 2'b10) md = 1;
            else begin
                mc = up ? 0 : int'(max_val);
                mw = 1;
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge.
    task automatic cycle();
        #2;
        check("tc", 32'(tc), 32'(model_tc()));
        @(posedge clk);
        model_edge();
        #1;
        check("count", 32'(count), 32'(mc));
        check("wrap", 32'(wrap), 32'(mw));
        check("done", 32'(done), 32'(md));
    endtask

    task automatic drive(input logic e, input logic c, input logic l,
                         input logic [3:0] lv, input logic u,
                         input logic [3:0] mx, input logic [1:0] md_i);
        en = e; clr = c; load = l; load_val = lv;
        up = u; max_val = mx; mode = md_i;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        cen = 1'b0; cclr = 1'b0;
        drive(0, 0, 0, 0, 1, 9, 0);
        mc = 3; mw = 0; md = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd3);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run(3);

        // Decade wrap up
        drive(0, 1, 0, 0, 1, 9, 0); cycle();
        drive(1, 0, 0, 0, 1, 9, 0); run(12);

        // Down wrap, then out-of-range up
        drive(0, 0, 1, 1, 0, 5, 0); cycle();
        drive(1, 0, 0, 0, 0, 5, 0); run(4);
        drive(0, 0, 1, 12, 1, 5, 0); cycle();
        drive(1, 0, 0, 0, 1, 5, 0); run(2);

        // Saturate then one-shot
        drive(0, 1, 0, 0, 1, 7, 1); cycle();
        drive(1, 0, 0, 0, 1, 7, 1); run(10);
        drive(0, 1, 0, 0, 1, 7, 2); cycle();
        drive(1, 0, 0, 0, 1, 7, 2); run(10);
        check("oneshot_done", 32'(done), 32'd1);
        drive(1, 0, 0, 0, 0, 7, 0); run(2);

        // Asynchronous reset with done pending, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        mc = 3; mw = 0; md = 0;
        check("async_count", 32'(count), 32'd3);
        check("async_done", 32'(done), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 9, 0); run(3);
        drive(0, 1, 0, 0, 1, 7, 2); cycle();

        // Priority
        drive(1, 0, 0, 0, 1, 9, 0); run(2);
        drive(1, 1, 1, 6, 1, 9, 0); cycle();
        check("prio_clr", 32'(count), 32'd0);
        drive(1, 0, 1, 6, 1, 9, 0); cycle();
        check("prio_load", 32'(count), 32'd6);

        // max_val = 0: divide-by-1 in wrap mode
        drive(1, 0, 0, 0, 1, 0, 0); run(4);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(3, 0) != 0,
                  $urandom_range(24, 0) == 0,
                  $urandom_range(11, 0) == 0,
                  4'($urandom), 1'($urandom),
                  (i % 50 < 10) ? 4'($urandom_range(2, 0)) : 4'($urandom),
                  2'($urandom));
            cycle();
        end

        // Two-stage decade cascade
        drive(0, 0, 0, 0, 1, 9, 0);
        cclr = 1'b1;
        @(posedge clk);
        #1;
        cclr = 1'b0;
        cen = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            check("c0_count", 32'(c0cnt), 32'(i % 10));
            check("c1_count", 32'(c1cnt), 32'((i / 10) % 10));
            check("c1_wrap", 32'(w1), 32'(i == 100));
            if (w1) pulses++;
        end
        check("c1_pulses", 32'(pulses), 32'd1);
        cen = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
